// File: rtl/srrc_folded_sym_fir_if.sv
// Bundle of sample, coefficient-load and result signals for the folded
// symmetric SRRC filter. The master side drives samples and coefficients,
// and the slave side returns the filtered output and status.
interface srrc_folded_sym_fir_if #(
  parameter int DATA_W  = 18,
  parameter int COEFF_W = 18,
  parameter int ADDR_W  = 6
);
  logic                      sam_clk_en;
  logic signed [DATA_W-1:0]  x_in;
  logic                      coeff_wr_en;
  logic [ADDR_W-1:0]         coeff_addr;
  logic signed [COEFF_W-1:0] coeff_data;
  logic signed [DATA_W-1:0]  y;
  logic                      y_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output sam_clk_en, x_in, coeff_wr_en, coeff_addr, coeff_data,
    input  y, y_valid, busy, overrun
  );

  modport slave (
    input  sam_clk_en, x_in, coeff_wr_en, coeff_addr, coeff_data,
    output y, y_valid, busy, overrun
  );
endinterface

// File: rtl/srrc_folded_sym_fir.sv
// Time-shared symmetric odd-length FIR for SRRC pulse shaping.
// Each accepted sample starts a run of HALF_COEFF_LEN+1 pre-add/MAC cycles
// that share a single multiplier. The result is then rounded half-up,
// saturated and presented with a one-cycle y_valid pulse.
module srrc_folded_sym_fir #(
  parameter int COEFF_LEN      = 105,
  parameter int HALF_COEFF_LEN = (COEFF_LEN - 1) / 2,
  parameter int DATA_W         = 18,
  parameter int COEFF_W        = 18,
  parameter int ACC_W          = 48,
  parameter int OUT_SHIFT      = 17,
  parameter int ADDR_W         = 6
) (
  input logic                clk,
  input logic                reset,
  srrc_folded_sym_fir_if.slave bus
);

  localparam int XIDX_W = $clog2(COEFF_LEN);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEFF_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);

  logic [1:0]                state;
  logic [ADDR_W-1:0]         k;
  logic signed [DATA_W-1:0]  x [COEFF_LEN];
  logic signed [COEFF_W-1:0] b [HALF_COEFF_LEN + 1];
  logic signed [ACC_W-1:0]   acc;

  logic [XIDX_W-1:0]         kx;
  logic [XIDX_W-1:0]         mk;
  logic signed [PRE_W-1:0]   pre;
  logic signed [COEFF_W-1:0] coef;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W:0]     rsum;
  logic signed [ACC_W:0]     rsh;
  logic                      fits;
  logic signed [DATA_W-1:0]  ysat;

  // Fold the mirrored tap pair (the centre tap stands alone) and weight it by the shared coefficient.
  always_comb begin
    kx   = XIDX_W'(k);
    mk   = XIDX_W'(COEFF_LEN - 1) - kx;
    coef = b[k];
    if (k == ADDR_W'(HALF_COEFF_LEN)) begin
      pre = {x[kx][DATA_W-1], x[kx]};
    end else begin
      pre = {x[kx][DATA_W-1], x[kx]} + {x[mk][DATA_W-1], x[mk]};
    end
    prod = PROD_W'(pre) * PROD_W'(coef);
  end

  // Round half-up at OUT_SHIFT. Any result outside the output range clamps to the nearest rail instead of wrapping.
  always_comb begin
    rsum = {acc[ACC_W-1], acc} + RND;
    rsh  = rsum >>> OUT_SHIFT;
    fits = (&rsh[ACC_W:DATA_W-1]) | ~(|rsh[ACC_W:DATA_W-1]);
    if (fits) begin
      ysat = rsh[DATA_W-1:0];
    end else if (rsh[ACC_W]) begin
      ysat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      ysat = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // The sequencer handles sample intake, coefficient loads, the MAC run and the output/status registers.
  // k stops at the centre index rather than running past the end of the bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      acc         <= '0;
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
      for (int i = 0; i < COEFF_LEN; i++) x[i] <= '0;
      for (int i = 0; i <= HALF_COEFF_LEN; i++) b[i] <= '0;
    end else begin
      bus.y_valid <= 1'b0;
      if (bus.sam_clk_en && (state != IDLE)) begin
        bus.overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.coeff_wr_en && (bus.coeff_addr <= ADDR_W'(HALF_COEFF_LEN))) begin
            b[bus.coeff_addr] <= bus.coeff_data;
          end
          if (bus.sam_clk_en) begin
            x[0] <= bus.x_in;
            for (int i = 1; i < COEFF_LEN; i++) x[i] <= x[i-1];
            k        <= '0;
            acc      <= '0;
            state    <= MAC;
            bus.busy <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (k == ADDR_W'(HALF_COEFF_LEN)) begin
            state <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          bus.y       <= ysat;
          bus.y_valid <= 1'b1;
          state       <= IDLE;
          bus.busy    <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srrc_folded_sym_fir.sv
// Scoreboard bench for srrc_folded_sym_fir. The stimulus pushes a
// hand-computed y value and its due cycle for each accepted sample. The
// monitor pops and compares them whenever y_valid pulses.
module tb_srrc_folded_sym_fir;

  localparam int LAT = 54;
  localparam int GAP = 60;

  typedef struct {
    int y_exp;
    int edge_exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cycle_count = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  srrc_folded_sym_fir_if #(.DATA_W(18), .COEFF_W(18), .ADDR_W(6)) bus ();

  srrc_folded_sym_fir dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Count active edges so the monitor can check output latency
  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle_count);
    end
  endtask

  // Monitor: each y_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_y_valid: got pulse at cycle %0d expected none", cycle_count);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("y", bus.y, mon_e.y_exp);
        checkOutput("latency", cycle_count, mon_e.edge_exp);
      end
    end
  end

  task automatic applyStimulus(input int xval, input int yexp, input bit push,
                               input bit wr, input int waddr, input int wdata);
    exp_t e;
    @(negedge clk);
    bus.sam_clk_en  = 1'b1;
    bus.x_in        = 18'(xval);
    bus.coeff_wr_en = wr;
    bus.coeff_addr  = 6'(waddr);
    bus.coeff_data  = 18'(wdata);
    if (push) begin
      e.y_exp    = yexp;
      e.edge_exp = cycle_count + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.sam_clk_en  = 1'b0;
    bus.coeff_wr_en = 1'b0;
  endtask

  task automatic applyCoeff(input int addr, input int data);
    @(negedge clk);
    bus.coeff_wr_en = 1'b1;
    bus.coeff_addr  = 6'(addr);
    bus.coeff_data  = 18'(data);
    @(negedge clk);
    bus.coeff_wr_en = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic doReset();
    waitDrain();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.sam_clk_en  = 1'b0;
    bus.x_in        = '0;
    bus.coeff_wr_en = 1'b0;
    bus.coeff_addr  = '0;
    bus.coeff_data  = '0;
    gap(3);
    reset = 1'b0;
    checkOutput("reset_y", bus.y, 0);
    checkOutput("reset_y_valid", int'(bus.y_valid), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_overrun", int'(bus.overrun), 0);

    // Centre tap and latency: the impulse reaches x[52] on the 53rd strobe
    $display("[TB] centre tap / latency");
    applyCoeff(52, 65536);
    for (int n = 1; n <= 61; n++) begin
      applyStimulus((n == 1) ? 131071 : 0, (n == 53) ? 65536 : 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // Symmetry: b[0] weights both x[0] and x[104]
    $display("[TB] symmetry");
    doReset();
    applyCoeff(0, 65536);
    for (int n = 1; n <= 106; n++) begin
      applyStimulus((n == 1) ? 131071 : 0, (n == 1 || n == 105) ? 65536 : 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // Positive saturation: one tap gives 131070, two or more overflow
    $display("[TB] saturation positive");
    doReset();
    for (int a = 0; a <= 52; a++) applyCoeff(a, 131071);
    for (int n = 1; n <= 110; n++) begin
      applyStimulus(131071, (n == 1) ? 131070 : 131071, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // Negative saturation: one tap gives -131071, then clamps to -131072
    $display("[TB] saturation negative");
    doReset();
    for (int a = 0; a <= 52; a++) applyCoeff(a, 131071);
    for (int n = 1; n <= 110; n++) begin
      applyStimulus(-131072, (n == 1) ? -131071 : -131072, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // Overrun: a second strobe 5 clks later is dropped and the flag sticks
    $display("[TB] overrun");
    doReset();
    applyCoeff(52, 65536);
    applyStimulus(131071, 0, 1'b1, 1'b0, 0, 0);
    gap(3);
    checkOutput("busy_mid_mac", int'(bus.busy), 1);
    applyStimulus(0, 0, 1'b0, 1'b0, 0, 0);
    checkOutput("overrun_set", int'(bus.overrun), 1);
    gap(GAP);
    waitDrain();
    gap(GAP);
    for (int n = 2; n <= 53; n++) begin
      applyStimulus(0, (n == 53) ? 65536 : 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end
    checkOutput("overrun_sticky", int'(bus.overrun), 1);

    // Reset at E10 discards the MAC and clears y (65536) and the overrun flag
    $display("[TB] reset mid-MAC");
    waitDrain();
    applyStimulus(0, 0, 1'b0, 1'b0, 0, 0);
    gap(9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_y", bus.y, 0);
    checkOutput("midreset_y_valid", int'(bus.y_valid), 0);
    checkOutput("midreset_busy", int'(bus.busy), 0);
    checkOutput("midreset_overrun", int'(bus.overrun), 0);
    gap(2 * GAP);
    for (int n = 1; n <= 53; n++) begin
      applyStimulus((n == 1) ? 131071 : 0, 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // Writes made while busy and writes to out-of-range addresses must not touch the bank
    $display("[TB] coefficient write rules");
    doReset();
    applyCoeff(52, 65536);
    applyStimulus(131071, 0, 1'b1, 1'b0, 0, 0);
    gap(3);
    checkOutput("busy_at_write", int'(bus.busy), 1);
    applyCoeff(52, 32768);
    gap(GAP);
    applyCoeff(60, 32768);
    for (int n = 2; n <= 53; n++) begin
      applyStimulus(0, (n == 53) ? 65536 : 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end

    // A write on the same edge as the strobe is used by that output
    doReset();
    for (int n = 1; n <= 52; n++) begin
      applyStimulus((n == 1) ? 131071 : 0, 0, 1'b1, 1'b0, 0, 0);
      gap(GAP - 1);
    end
    applyStimulus(0, 32768, 1'b1, 1'b1, 52, 32768);
    gap(GAP - 1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
